// File: rtl/serial_adder_seq.sv
// Bit-serial adder/subtractor: a single full-adder cell processes one bit pair per clock, LSB first.
// Build option SERIAL_ADDER_SUB_EN enables subtraction via the sub port; otherwise sub is ignored.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sr_reg, b_sr_reg, r_sr_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg, c_msb_in_reg;
    logic             cout_reg, overflow_reg, done_reg;

    logic             s_bit, c_bit, last_bit;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract as a + ~b + 1: invert b at load and seed the carry with 1.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_load     = b;
    assign carry_load = 1'b0;
`endif

    assign s_bit    = a_sr_reg[0] ^ b_sr_reg[0] ^ carry_reg;
    assign c_bit    = (a_sr_reg[0] & b_sr_reg[0]) | (a_sr_reg[0] & carry_reg) | (b_sr_reg[0] & carry_reg);
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        case (state_reg)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            a_sr_reg     <= '0;
            b_sr_reg     <= '0;
            r_sr_reg     <= '0;
            cnt_reg      <= '0;
            carry_reg    <= 1'b0;
            c_msb_in_reg <= 1'b0;
            sum_reg      <= '0;
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sr_reg  <= a;
                        b_sr_reg  <= b_load;
                        carry_reg <= carry_load;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    r_sr_reg  <= {s_bit, r_sr_reg[WIDTH-1:1]};
                    a_sr_reg  <= a_sr_reg >> 1;
                    b_sr_reg  <= b_sr_reg >> 1;
                    carry_reg <= c_bit;
                    cnt_reg   <= cnt_reg + CW'(1);
                    // Carry entering the MSB cell, needed for signed overflow.
                    if (last_bit) c_msb_in_reg <= carry_reg;
                end
                DONE: begin
                    sum_reg      <= r_sr_reg;
                    cout_reg     <= carry_reg;
                    overflow_reg <= c_msb_in_reg ^ carry_reg;
                    done_reg     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done     = done_reg;
    assign sum      = sum_reg;
    assign cout     = cout_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Scoreboard bench for serial_adder_seq: stimulus pushes arithmetic-model results, a monitor pops on done.
module tb_serial_adder_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, overflow;
    logic [W-1:0] sum;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    serial_adder_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    // Plain integer arithmetic: unsigned result for sum/cout, signed range test for overflow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t   r;
        longint ux, uy, sx, sy, full, sres, m;
        logic   do_sub;
`ifdef SERIAL_ADDER_SUB_EN
        do_sub = s;
`else
        do_sub = 1'b0 & s;
`endif
        m  = longint'(1) << W;
        ux = longint'(x);
        uy = longint'(y);
        sx = x[W-1] ? ux - m : ux;
        sy = y[W-1] ? uy - m : uy;
        if (do_sub) begin
            full = ux + (m - uy);
            sres = sx - sy;
        end else begin
            full = ux + uy;
            sres = sx + sy;
        end
        r.s = full[W-1:0];
        r.c = full[W];
        r.v = (sres > (m / 2 - 1)) || (sres < -(m / 2));
        return r;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sum", 64'(sum), 64'(e.s));
                chk("cout", 64'(cout), 64'(e.c));
                chk("overflow", 64'(overflow), 64'(e.v));
            end
        end
    end

    // mode 0: plain op; 1: start re-pulsed in RUN; 2: reset mid-run; 3: start held for two ops
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts, input int mode);
        int           busy_n, done_n, first_done, second_done;
        logic [W-1:0] prev_sum;
        logic         hold_ok;
        busy_n = 0; done_n = 0; first_done = 0; second_done = 0; hold_ok = 1'b1;
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        if (mode != 2) exp_q.push_back(model(ta, tb_v, ts));
        prev_sum = sum;
        @(posedge clk);
        for (int k = 1; k <= 2 * W + 6; k++) begin
            @(negedge clk);
            busy_n += int'(busy);
            if (done) begin
                done_n++;
                if (done_n == 1) first_done = k;
                if (done_n == 2) second_done = k;
            end
            if (((mode != 2) && k <= W) || ((mode == 2) && k <= 4))
                if (sum !== prev_sum) hold_ok = 1'b0;
            if (k == 1) begin
                a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
                if (mode == 3) exp_q.push_back(model(a, b, sub));
                else start = 1'b0;
            end
            if (mode == 3 && k == W + 3) start = 1'b0;
            if (mode == 1 && k == 3) begin
                start = 1'b1; a = ~ta; b = ~tb_v;
            end
            if (mode == 1 && k == 4) start = 1'b0;
            if (mode == 2 && k == 4) rst_n = 1'b0;
            if (mode == 2 && k == 5) rst_n = 1'b1;
        end
        chk("result_hold", 64'(hold_ok), 64'd1);
        case (mode)
            2: begin
                chk("rst_busy_cycles", 64'(busy_n), 64'd4);
                chk("rst_no_done", 64'(done_n), 64'd0);
                chk("rst_outputs", {sum, cout, overflow}, 64'd0);
            end
            3: begin
                chk("held_busy_cycles", 64'(busy_n), 64'(2 * W));
                chk("held_done_count", 64'(done_n), 64'd2);
                chk("held_done1_time", 64'(first_done), 64'(W + 2));
                chk("held_done2_time", 64'(second_done), 64'(2 * W + 4));
            end
            default: begin
                chk("busy_cycles", 64'(busy_n), 64'(W));
                chk("done_count", 64'(done_n), 64'd1);
                chk("done_time", 64'(first_done), 64'(W + 2));
            end
        endcase
        $display("op a=%0h b=%0h sub=%0b mode=%0d -> sum=%0h cout=%0b ovf=%0b", ta, tb_v, ts, mode, sum, cout, overflow);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("in_reset", {busy, done, sum, cout, overflow}, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_after_reset", {busy, done, sum, cout, overflow}, 64'd0);
        end
        run_op(8'h5A, 8'h3C, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'h80, 8'h80, 1'b0, 0);
        run_op(8'h10, 8'h01, 1'b1, 0);
        run_op(8'h00, 8'h01, 1'b1, 0);
        run_op(8'h80, 8'h01, 1'b1, 0);
        run_op(8'h33, 8'h44, 1'b0, 1);
        run_op(8'hC3, 8'h7E, 1'b1, 3);
        run_op(8'h12, 8'h34, 1'b0, 2);
        run_op(8'h7F, 8'h01, 1'b0, 0);
        for (int i = 0; i < 30; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
